// File: rtl/axis_pattern_master.sv
// Valid/ready stream source: arithmetic payload in bursts with a last marker,
// continuous / gapped / single-shot modes, plus accepted-beat and stall counters.
module axis_pattern_master #(
  parameter int                DATA_W     = 32,
  parameter int                BURST_LEN  = 4,
  parameter int                GAP_CYCLES = 2,
  parameter logic [DATA_W-1:0] START_VAL  = 1,
  parameter logic [DATA_W-1:0] STEP       = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic              ready,
  output logic              valid,
  output logic [DATA_W-1:0] data,
  output logic              last,
  output logic              busy,
  output logic [31:0]       beats_sent,
  output logic [15:0]       stall_cycles
);

  localparam int IDX_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BURST_LEN - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP} state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] payload_q, payload_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [1:0]        mode_q, mode_d;
  logic              armed_q, armed_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              busy_q, busy_d;
  logic [31:0]       beats_q, beats_d;
  logic [15:0]       stall_q, stall_d;
  logic              accept;

  assign accept = valid_q & ready;

  always_comb begin
    state_d   = state_q;
    payload_d = payload_q;
    idx_d     = idx_q;
    gap_d     = gap_q;
    mode_d    = mode_q;
    armed_d   = armed_q;
    beats_d   = beats_q;
    stall_d   = stall_q;

    if (accept) begin
      payload_d = payload_q + STEP;
      beats_d   = beats_q + 32'd1;
      idx_d     = idx_q + IDX_W'(1);
    end
    if (valid_q && !ready && stall_q != 16'hFFFF) begin
      stall_d = stall_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (!en) begin
          armed_d = 1'b1;
        end else if (armed_q) begin
          state_d = S_SEND;
          mode_d  = mode;
          idx_d   = '0;
        end
      end
      S_SEND: begin
        if (accept && idx_q == LAST_IDX) begin
          idx_d = '0;
          if (mode_q == 2'd2) armed_d = 1'b0;
          if (!en) begin
            state_d = S_IDLE;
          end else begin
            case (mode_q)
              2'd1: begin
                if (GAP_CYCLES > 0) begin
                  state_d = S_GAP;
                  gap_d   = GAP_LOAD;
                end else begin
                  mode_d = mode;
                end
              end
              2'd2:    state_d = S_IDLE;
              default: mode_d = mode;  // back-to-back burst, no bubble
            endcase
          end
        end
      end
      S_GAP: begin
        if (gap_q == '0) begin
          if (en) begin
            state_d = S_SEND;
            mode_d  = mode;
            idx_d   = '0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          gap_d = gap_q - GAP_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered, so they are derived from the next state.
    valid_d = (state_d == S_SEND);
    last_d  = valid_d && (idx_d == LAST_IDX);
    busy_d  = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      payload_q <= START_VAL;
      idx_q     <= '0;
      gap_q     <= '0;
      mode_q    <= 2'd0;
      armed_q   <= 1'b1;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      busy_q    <= 1'b0;
      beats_q   <= '0;
      stall_q   <= '0;
    end else begin
      state_q   <= state_d;
      payload_q <= payload_d;
      idx_q     <= idx_d;
      gap_q     <= gap_d;
      mode_q    <= mode_d;
      armed_q   <= armed_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      busy_q    <= busy_d;
      beats_q   <= beats_d;
      stall_q   <= stall_d;
    end
  end

  assign valid        = valid_q;
  assign data         = valid_q ? payload_q : '0;
  assign last         = last_q;
  assign busy         = busy_q;
  assign beats_sent   = beats_q;
  assign stall_cycles = stall_q;

endmodule

// File: tb/tb_axis_pattern_master.sv
// Directed bench for axis_pattern_master: a per-cycle vector table for the
// default configuration plus a hand sequence for an 8-bit wrapping instance.
module tb_axis_pattern_master;

  logic        clk = 1'b0;
  logic        rst_n, en, ready;
  logic [1:0]  mode;
  logic        valid, last, busy;
  logic [31:0] data, beats_sent;
  logic [15:0] stall_cycles;

  logic        rst2_n, en2, ready2;
  logic [1:0]  mode2;
  logic        valid2, last2, busy2;
  logic [7:0]  data2;
  logic [31:0] beats2;
  logic [15:0] stall2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  axis_pattern_master dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .ready(ready),
    .valid(valid), .data(data), .last(last), .busy(busy),
    .beats_sent(beats_sent), .stall_cycles(stall_cycles)
  );

  axis_pattern_master #(.DATA_W(8), .START_VAL(8'hFE)) dut8 (
    .clk(clk), .rst_n(rst2_n), .en(en2), .mode(mode2), .ready(ready2),
    .valid(valid2), .data(data2), .last(last2), .busy(busy2),
    .beats_sent(beats2), .stall_cycles(stall2)
  );

  typedef struct {
    bit          rst;
    bit          en;
    bit [1:0]    mode;
    bit          ready;
    bit          v;
    bit [31:0]   d;
    bit          l;
    bit          b;
    bit [31:0]   beats;
    bit [15:0]   stall;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit r, input bit e, input bit [1:0] m, input bit rd,
                     input bit v, input bit [31:0] d, input bit l, input bit b,
                     input bit [31:0] bt, input bit [15:0] st);
    vec_t x;
    x.rst = r; x.en = e; x.mode = m; x.ready = rd;
    x.v = v; x.d = d; x.l = l; x.b = b; x.beats = bt; x.stall = st;
    vecs.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; mode = 2'd0; ready = 1'b0;
    rst2_n = 1'b0; en2 = 1'b0; mode2 = 2'd0; ready2 = 1'b0;

    // Mode 0, ready always high: 1..11, last on 4 and 8
    for (int i = 0; i <= 10; i++)
      add(i == 0, 1, 0, 1, 1, 32'(i + 1), ((i + 1) % 4) == 0, 1, 32'(i), 0);
    // Mode 0, ready pattern 1,0,0,1,1
    add(1, 1, 0, 1, 1, 1, 0, 1, 0, 0);
    add(0, 1, 0, 1, 1, 2, 0, 1, 1, 0);
    add(0, 1, 0, 0, 1, 2, 0, 1, 1, 1);
    add(0, 1, 0, 0, 1, 2, 0, 1, 1, 2);
    add(0, 1, 0, 1, 1, 3, 0, 1, 2, 2);
    add(0, 1, 0, 1, 1, 4, 1, 1, 3, 2);
    // Mode 1: 1..4, two gap cycles, 5..8, gap again
    add(1, 1, 1, 1, 1, 1, 0, 1, 0, 0);
    add(0, 1, 1, 1, 1, 2, 0, 1, 1, 0);
    add(0, 1, 1, 1, 1, 3, 0, 1, 2, 0);
    add(0, 1, 1, 1, 1, 4, 1, 1, 3, 0);
    add(0, 1, 1, 1, 0, 0, 0, 1, 4, 0);
    add(0, 1, 1, 1, 0, 0, 0, 1, 4, 0);
    add(0, 1, 1, 1, 1, 5, 0, 1, 4, 0);
    add(0, 1, 1, 1, 1, 6, 0, 1, 5, 0);
    add(0, 1, 1, 1, 1, 7, 0, 1, 6, 0);
    add(0, 1, 1, 1, 1, 8, 1, 1, 7, 0);
    add(0, 1, 1, 1, 0, 0, 0, 1, 8, 0);
    // Mode 2: single shot, no restart until en toggles; mode change mid-burst ignored
    add(1, 1, 2, 1, 1, 1, 0, 1, 0, 0);
    add(0, 1, 2, 1, 1, 2, 0, 1, 1, 0);
    add(0, 1, 2, 1, 1, 3, 0, 1, 2, 0);
    add(0, 1, 2, 1, 1, 4, 1, 1, 3, 0);
    add(0, 1, 2, 1, 0, 0, 0, 0, 4, 0);
    add(0, 1, 2, 1, 0, 0, 0, 0, 4, 0);
    add(0, 1, 2, 1, 0, 0, 0, 0, 4, 0);
    add(0, 0, 2, 1, 0, 0, 0, 0, 4, 0);
    add(0, 1, 2, 1, 1, 5, 0, 1, 4, 0);
    add(0, 1, 2, 1, 1, 6, 0, 1, 5, 0);
    add(0, 1, 0, 1, 1, 7, 0, 1, 6, 0);
    add(0, 1, 0, 1, 1, 8, 1, 1, 7, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, 8, 0);
    add(0, 1, 0, 1, 0, 0, 0, 0, 8, 0);
    // en dropped at beat 2 while stalled: burst completes, then idle
    add(1, 1, 0, 1, 1, 1, 0, 1, 0, 0);
    add(0, 1, 0, 1, 1, 2, 0, 1, 1, 0);
    add(0, 0, 0, 0, 1, 2, 0, 1, 1, 1);
    add(0, 0, 0, 0, 1, 2, 0, 1, 1, 2);
    add(0, 0, 0, 1, 1, 3, 0, 1, 2, 2);
    add(0, 0, 0, 1, 1, 4, 1, 1, 3, 2);
    add(0, 0, 0, 1, 0, 0, 0, 0, 4, 2);
    add(0, 0, 0, 1, 0, 0, 0, 0, 4, 2);

    repeat (2) @(posedge clk);
    #1;

    foreach (vecs[i]) begin
      if (vecs[i].rst) begin
        rst_n = 1'b0;
        #1;
        chk("rst_valid", 32'(valid), 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_last", 32'(last), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_beats", beats_sent, 32'd0);
        chk("rst_stall", 32'(stall_cycles), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
      end
      en = vecs[i].en; mode = vecs[i].mode; ready = vecs[i].ready;
      @(posedge clk);
      #1;
      $display("vec %0d en=%0d mode=%0d ready=%0d -> valid=%0d data=%0d last=%0d busy=%0d beats=%0d stall=%0d",
               i, en, mode, ready, valid, data, last, busy, beats_sent, stall_cycles);
      chk($sformatf("v%0d_valid", i), 32'(valid), 32'(vecs[i].v));
      chk($sformatf("v%0d_data", i), data, vecs[i].d);
      chk($sformatf("v%0d_last", i), 32'(last), 32'(vecs[i].l));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].b));
      chk($sformatf("v%0d_beats", i), beats_sent, vecs[i].beats);
      chk($sformatf("v%0d_stall", i), 32'(stall_cycles), 32'(vecs[i].stall));
    end

    // 8-bit instance: wrap FE, FF, 00, 01, then async reset mid-burst
    begin
      logic [7:0] exp8 [6];
      exp8 = '{8'hFE, 8'hFF, 8'h00, 8'h01, 8'h02, 8'h03};
      @(negedge clk);
      rst2_n = 1'b1; en2 = 1'b1; mode2 = 2'd0; ready2 = 1'b1;
      for (int k = 0; k < 6; k++) begin
        @(posedge clk);
        #1;
        $display("dut8 beat %0d -> valid=%0d data=%02h last=%0d", k, valid2, data2, last2);
        chk($sformatf("w%0d_valid", k), 32'(valid2), 32'd1);
        chk($sformatf("w%0d_data", k), 32'(data2), 32'(exp8[k]));
        chk($sformatf("w%0d_last", k), 32'(last2), 32'(k == 3));
      end
      chk("w_beats", beats2, 32'd5);
      rst2_n = 1'b0;
      #1;
      $display("dut8 async reset -> valid=%0d data=%02h beats=%0d", valid2, data2, beats2);
      chk("w_rst_valid", 32'(valid2), 32'd0);
      chk("w_rst_data", 32'(data2), 32'd0);
      chk("w_rst_last", 32'(last2), 32'd0);
      chk("w_rst_busy", 32'(busy2), 32'd0);
      chk("w_rst_beats", beats2, 32'd0);
      chk("w_rst_stall", 32'(stall2), 32'd0);
      @(negedge clk);
      rst2_n = 1'b1;
      @(posedge clk);
      #1;
      $display("dut8 restart -> valid=%0d data=%02h", valid2, data2);
      chk("w_restart_valid", 32'(valid2), 32'd1);
      chk("w_restart_data", 32'(data2), 32'hFE);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
